// File: rtl/serin_receiver.sv
// Serial-input receive engine: synchronises SID, frames start/data/stop bits on the
// channel-4 bit-rate strobe, and reports the received byte and status to IRQ/SKSTAT.
module serin_receiver #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enp,
    input  logic                 sid,
    input  logic                 bitTick,
    input  logic                 asyncMode,
    input  logic                 serinRd,
    input  logic                 clrErr,
    output logic                 resyncSerClk,
    output logic [DATA_BITS-1:0] serinData,
    output logic                 serinIrq,
    output logic                 byteReady,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 sidSync
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sid_prev_r;
    logic [1:0]             state_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;

    logic                   sid_s;
    logic                   fall_s;
    logic                   done_s;
    logic                   fe_set_s;
    logic                   ov_set_s;

    assign sid_s   = sync_r[SYNC_STAGES-1];
    assign sidSync = sid_s;

    // SID synchroniser and previous-value flop; preset high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r     <= {SYNC_STAGES{1'b1}};
            sid_prev_r <= 1'b1;
        end else if (enp) begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], sid};
            sid_prev_r <= sid_s;
        end else begin
            sync_r     <= sync_r;
            sid_prev_r <= sid_prev_r;
        end
    end

    // Edge detect and stop-tick status events
    always_comb begin
        fall_s   = sid_prev_r & ~sid_s;
        done_s   = (state_r == ST_STOP) & bitTick;
        fe_set_s = done_s & ~sid_s;
        ov_set_s = done_s & byteReady & ~serinRd;
    end

    // Frame state machine, shift register and single-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= CNT_ZERO;
            shift_r      <= {DATA_BITS{1'b0}};
            serinData    <= {DATA_BITS{1'b0}};
            serinIrq     <= 1'b0;
            resyncSerClk <= 1'b0;
        end else if (enp) begin
            serinIrq     <= 1'b0;
            resyncSerClk <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Ticks are ignored here, so a tick on the edge cycle never counts as the start sample
                    if (fall_s) begin
                        state_r      <= ST_START;
                        resyncSerClk <= asyncMode;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (bitTick) begin
                        if (sid_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= CNT_ZERO;
                        end
                    end else begin
                        state_r <= ST_START;
                    end
                end
                ST_DATA: begin
                    if (bitTick) begin
                        shift_r   <= {sid_s, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= ST_STOP;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (bitTick) begin
                        serinData <= shift_r;
                        serinIrq  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_STOP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Status flags: completion/error set has priority over read/clear strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            byteReady <= 1'b0;
            frameErr  <= 1'b0;
            overrun   <= 1'b0;
        end else if (enp) begin
            if (done_s) begin
                byteReady <= 1'b1;
            end else if (serinRd) begin
                byteReady <= 1'b0;
            end else begin
                byteReady <= byteReady;
            end

            if (fe_set_s) begin
                frameErr <= 1'b1;
            end else if (clrErr) begin
                frameErr <= 1'b0;
            end else begin
                frameErr <= frameErr;
            end

            if (ov_set_s) begin
                overrun <= 1'b1;
            end else if (clrErr) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end
        end else begin
            byteReady <= byteReady;
            frameErr  <= frameErr;
            overrun   <= overrun;
        end
    end

endmodule

// File: tb/tb_serin_receiver.sv
// Scoreboard bench for serin_receiver: frames are driven bit by bit, expected bytes and
// flags are queued at the stop tick and compared when serinIrq fires.
module tb_serin_receiver;

    logic       clk = 1'b0;
    logic       reset, enp, sid, bitTick, asyncMode, serinRd, clrErr;
    logic       resyncSerClk, serinIrq, byteReady, frameErr, overrun, sidSync;
    logic [7:0] serinData;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_m;

    int   n_cmp = 0;
    int   n_err = 0;
    int   irq_cnt = 0;
    int   rs_cnt = 0;
    logic irq_prev = 1'b0;
    logic rs_prev = 1'b0;
    logic m_br = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
    int   irq0, rs0;
    logic [7:0] abort_byte;

    always #5 clk = ~clk;

    serin_receiver #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .enp(enp), .sid(sid), .bitTick(bitTick),
        .asyncMode(asyncMode), .serinRd(serinRd), .clrErr(clrErr),
        .resyncSerClk(resyncSerClk), .serinData(serinData), .serinIrq(serinIrq),
        .byteReady(byteReady), .frameErr(frameErr), .overrun(overrun), .sidSync(sidSync)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One bit period: level held 4 cycles, tick (with optional strobes) on the 5th, then 3 more
    task automatic bitp(input logic v, input logic rd, input logic clr);
        sid = v;
        repeat (4) cyc();
        bitTick = 1'b1;
        serinRd = rd;
        clrErr  = clr;
        cyc();
        bitTick = 1'b0;
        serinRd = 1'b0;
        clrErr  = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_stop,
                              input logic clr_stop);
        exp_t e;
        int   rs_start;
        rs_start = rs_cnt;
        bitp(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bitp(d[i], 1'b0, 1'b0);
        m_fe = ~stop | (m_fe & ~clr_stop);
        m_ov = (m_br & ~rd_stop) | (m_ov & ~clr_stop);
        m_br = 1'b1;
        e.d  = d;
        e.fe = m_fe;
        e.ov = m_ov;
        sb_q.push_back(e);
        bitp(stop, rd_stop, clr_stop);
        chk("resync_count", rs_cnt - rs_start, 32'(asyncMode));
        chk("byte_ready", byteReady, m_br);
    endtask

    task automatic check_reset_values();
        chk("rst_data", serinData, 32'h0);
        chk("rst_irq", serinIrq, 32'h0);
        chk("rst_resync", resyncSerClk, 32'h0);
        chk("rst_byte_ready", byteReady, 32'h0);
        chk("rst_frame_err", frameErr, 32'h0);
        chk("rst_overrun", overrun, 32'h0);
        chk("rst_sid_sync", sidSync, 32'h1);
    endtask

    // Output monitor: pops the scoreboard on each completion and checks pulse widths
    always @(negedge clk) begin
        if (serinIrq) begin
            irq_cnt++;
            chk("irq_pulse_width", irq_prev, 32'h0);
            if (sb_q.size() == 0) begin
                chk("irq_unexpected", 32'h1, 32'h0);
            end else begin
                e_m = sb_q.pop_front();
                chk("serin_data", serinData, e_m.d);
                chk("frame_err", frameErr, e_m.fe);
                chk("overrun", overrun, e_m.ov);
            end
        end
        if (resyncSerClk) begin
            rs_cnt++;
            chk("resync_pulse_width", rs_prev, 32'h0);
        end
        irq_prev = serinIrq;
        rs_prev  = resyncSerClk;
    end

    initial begin
        reset = 1'b1; enp = 1'b1; sid = 1'b1; bitTick = 1'b0;
        asyncMode = 1'b1; serinRd = 1'b0; clrErr = 1'b0;
        repeat (3) cyc();
        check_reset_values();
        reset = 1'b0;
        repeat (4) cyc();

        // Async frame 0x5A, then a lone read clears byteReady
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("data_5a", serinData, 32'h5A);
        serinRd = 1'b1; cyc(); serinRd = 1'b0; m_br = 1'b0;
        chk("rd_clears_ready", byteReady, m_br);

        // False start: glitch low, back high before the start sample
        irq0 = irq_cnt; rs0 = rs_cnt;
        sid = 1'b0; repeat (4) cyc();
        sid = 1'b1; repeat (4) cyc();
        bitTick = 1'b1; cyc(); bitTick = 1'b0; repeat (4) cyc();
        chk("false_start_irq", irq_cnt - irq0, 32'h0);
        chk("false_start_resync", rs_cnt - rs0, 32'h1);
        chk("false_start_data", serinData, 32'h5A);
        chk("false_start_fe", frameErr, 32'h0);

        // Framing error followed by a long break
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        irq0 = irq_cnt;
        for (int i = 0; i < 20; i++) bitp(1'b0, 1'b0, 1'b0);
        chk("break_no_frame", irq_cnt - irq0, 32'h0);
        chk("break_frame_err", frameErr, 32'h1);
        sid = 1'b1; repeat (8) cyc();
        serinRd = 1'b1; clrErr = 1'b1; cyc(); serinRd = 1'b0; clrErr = 1'b0;
        m_br = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        chk("clr_frame_err", frameErr, 32'h0);

        // Overrun, lone clear, then read coincident with completion
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        chk("overrun_set", overrun, 32'h1);
        chk("data_22", serinData, 32'h22);
        clrErr = 1'b1; cyc(); clrErr = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        chk("clr_overrun", overrun, 32'h0);
        chk("clr_keeps_ready", byteReady, 32'h1);
        send_frame(8'h33, 1'b1, 1'b1, 1'b0);

        // Clear coincident with a new framing error and overrun: set wins
        send_frame(8'h44, 1'b0, 1'b0, 1'b1);
        sid = 1'b1; repeat (8) cyc();

        // Read strobe ignored while enp is low
        serinRd = 1'b1; enp = 1'b0; cyc(); enp = 1'b1; serinRd = 1'b0;
        chk("enp_gates_read", byteReady, m_br);
        serinRd = 1'b1; clrErr = 1'b1; cyc(); serinRd = 1'b0; clrErr = 1'b0;
        m_br = 1'b0; m_fe = 1'b0; m_ov = 1'b0;

        // Synchronous mode: no resync pulse
        asyncMode = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("data_a5", serinData, 32'hA5);

        // Reset in the middle of the data bits aborts the frame
        irq0 = irq_cnt;
        abort_byte = 8'h6B;
        bitp(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bitp(abort_byte[i], 1'b0, 1'b0);
        reset = 1'b1; cyc(); reset = 1'b0;
        m_br = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        sid = 1'b1;
        check_reset_values();
        repeat (40) cyc();
        chk("abort_no_irq", irq_cnt - irq0, 32'h0);
        chk("abort_data", serinData, 32'h0);

        // Receiver recovers after the abort
        asyncMode = 1'b1;
        send_frame(8'h96, 1'b1, 1'b0, 1'b0);
        chk("scoreboard_drained", sb_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
